// File: rtl/vend_sequencer.sv
// vend_sequencer: coin-collecting vend controller with dispense handshake, change refund and idle timeout.
module vend_sequencer #(
    parameter int PRICE   = 3,
    parameter int TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       onein,
    input  logic       twoin,
    input  logic       fivein,
    input  logic       cancel,
    input  logic       disp_ready,
    input  logic       disp_done,
    input  logic       hop_ready,
    output logic       water,
    output logic       change,
    output logic       coin_rej,
    output logic [3:0] credit,
    output logic       busy
);
    typedef enum logic [2:0] {IDLE, COLLECT, VEND, WAIT_DONE, REFUND} state_t;

    localparam logic [3:0] P     = 4'(PRICE);
    localparam logic [7:0] TLAST = 8'(TIMEOUT - 1);

    state_t     state;
    logic [7:0] tcnt;
    logic [3:0] sum;
    logic [3:0] new_credit;

    assign sum        = {3'b0, onein} + {2'b0, twoin, 1'b0} + {1'b0, fivein, 1'b0, fivein};
    assign new_credit = credit + sum;
    assign busy       = state == VEND || state == WAIT_DONE || state == REFUND;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            credit   <= 4'd0;
            tcnt     <= 8'd0;
            water    <= 1'b0;
            change   <= 1'b0;
            coin_rej <= 1'b0;
        end else begin
            water    <= 1'b0;
            change   <= 1'b0;
            coin_rej <= busy && sum != 4'd0;
            case (state)
                IDLE: if (sum != 4'd0) begin
                    credit <= sum;
                    tcnt   <= 8'd0;
                    state  <= sum >= P ? VEND : COLLECT;
                end
                COLLECT: begin
                    credit <= new_credit;
                    // cancel wins over a vend that the same-cycle coin would have enabled
                    if (cancel) state <= REFUND;
                    else if (new_credit >= P) state <= VEND;
                    else if (sum != 4'd0) tcnt <= 8'd0;
                    else if (tcnt == TLAST) state <= REFUND;
                    else tcnt <= tcnt + 8'd1;
                end
                VEND: if (disp_ready) begin
                    water  <= 1'b1;
                    credit <= credit - P;
                    state  <= WAIT_DONE;
                end
                WAIT_DONE: if (disp_done) state <= credit != 4'd0 ? REFUND : IDLE;
                REFUND: begin
                    if (credit == 4'd0) state <= IDLE;
                    else if (hop_ready) begin
                        change <= 1'b1;
                        credit <= credit - 4'd1;
                        if (credit == 4'd1) state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vend_sequencer.sv
// tb_vend_sequencer: directed scenarios plus random traffic checked cycle by cycle against a behavioural model.
module tb_vend_sequencer;
    localparam int PRICE   = 3;
    localparam int TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       reset, onein, twoin, fivein, cancel, disp_ready, disp_done, hop_ready;
    logic       water, change, coin_rej, busy;
    logic [3:0] credit;

    int n_vec = 0, n_err = 0;
    int nwat, nchg, nrej;

    // model: money held, activity phase, coin-free cycles spent collecting, expected pulses
    int m_cr, m_phase, m_quiet;
    bit m_w, m_c, m_r;
    localparam int PH_IDLE = 0, PH_COLLECT = 1, PH_VEND = 2, PH_WAIT = 3, PH_REFUND = 4;

    vend_sequencer #(.PRICE(PRICE), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .onein(onein), .twoin(twoin), .fivein(fivein),
        .cancel(cancel), .disp_ready(disp_ready), .disp_done(disp_done), .hop_ready(hop_ready),
        .water(water), .change(change), .coin_rej(coin_rej), .credit(credit), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clock();
        int s;
        s = int'(onein) + 2 * int'(twoin) + 5 * int'(fivein);
        m_w = 0;
        m_c = 0;
        m_r = m_phase >= PH_VEND && s > 0;
        if (m_phase == PH_IDLE) begin
            if (s > 0) begin
                m_cr = s;
                m_quiet = 0;
                m_phase = s >= PRICE ? PH_VEND : PH_COLLECT;
            end
        end else if (m_phase == PH_COLLECT) begin
            m_cr += s;
            if (cancel) m_phase = PH_REFUND;
            else if (m_cr >= PRICE) m_phase = PH_VEND;
            else if (s > 0) m_quiet = 0;
            else begin
                m_quiet++;
                if (m_quiet >= TIMEOUT) m_phase = PH_REFUND;
            end
        end else if (m_phase == PH_VEND) begin
            if (disp_ready) begin
                m_w = 1;
                m_cr -= PRICE;
                m_phase = PH_WAIT;
            end
        end else if (m_phase == PH_WAIT) begin
            if (disp_done) m_phase = m_cr > 0 ? PH_REFUND : PH_IDLE;
        end else if (hop_ready && m_cr > 0) begin
            m_c = 1;
            m_cr--;
            if (m_cr == 0) m_phase = PH_IDLE;
        end
    endtask

    task automatic compare();
        chk("water", 8'(water), 8'(m_w));
        chk("change", 8'(change), 8'(m_c));
        chk("coin_rej", 8'(coin_rej), 8'(m_r));
        chk("credit", 8'(credit), 8'(m_cr));
        chk("busy", 8'(busy), 8'(m_phase >= PH_VEND));
        chk("water_change_excl", 8'(water & change), 8'd0);
    endtask

    task automatic step();
        @(posedge clk);
        model_clock();
        #1;
        compare();
        nwat += int'(water);
        nchg += int'(change);
        nrej += int'(coin_rej);
    endtask

    task automatic clr();
        {onein, twoin, fivein, cancel, disp_ready, disp_done, hop_ready} = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        m_cr = 0;
        m_phase = PH_IDLE;
        m_quiet = 0;
        {m_w, m_c, m_r} = '0;
        #3;
        compare();
        reset = 1'b0;
        {nwat, nchg, nrej} = '0;
    endtask

    initial begin
        reset = 1'b0;
        clr();
        #1;
        do_reset();
        // exact pay
        twoin = 1; step(); clr();
        onein = 1; step(); clr();
        disp_ready = 1; step(); clr();
        disp_done = 1; step(); clr();
        chk("exact_water", 8'(nwat), 8'd1);
        chk("exact_change", 8'(nchg), 8'd0);
        chk("exact_idle", 8'(busy), 8'd0);
        // overpay
        do_reset();
        fivein = 1; step(); clr();
        disp_ready = 1; step(); clr();
        chk("ovp_credit", 8'(credit), 8'd2);
        disp_done = 1; step(); clr();
        hop_ready = 1; step(); chk("ovp_credit1", 8'(credit), 8'd1); step(); clr();
        chk("ovp_water", 8'(nwat), 8'd1);
        chk("ovp_change", 8'(nchg), 8'd2);
        chk("ovp_idle", 8'(busy), 8'd0);
        // simultaneous coins, then a coin during refund
        do_reset();
        {onein, twoin, fivein} = 3'b111; step(); clr();
        chk("sim_credit", 8'(credit), 8'd8);
        disp_ready = 1; step(); clr();
        disp_done = 1; step(); clr();
        hop_ready = 1; onein = 1; step(); onein = 0;
        for (int i = 0; i < 5; i++) step();
        clr();
        chk("sim_change", 8'(nchg), 8'd5);
        chk("sim_rej", 8'(nrej), 8'd1);
        chk("sim_idle", 8'(busy), 8'd0);
        // cancel with hopper stall
        do_reset();
        onein = 1; step(); clr();
        cancel = 1; step(); clr();
        for (int i = 0; i < 3; i++) step();
        chk("cancel_hold", 8'(credit), 8'd1);
        chk("cancel_busy", 8'(busy), 8'd1);
        hop_ready = 1; step(); clr();
        chk("cancel_change", 8'(nchg), 8'd1);
        chk("cancel_water", 8'(nwat), 8'd0);
        // timeout, with a coin on the 15th quiet cycle restarting the count
        do_reset();
        onein = 1; step(); clr();
        for (int i = 0; i < 14; i++) step();
        onein = 1; step(); clr();
        for (int i = 0; i < TIMEOUT - 1; i++) step();
        chk("to_restart", 8'(busy), 8'd0);
        step();
        chk("to_refund", 8'(busy), 8'd1);
        hop_ready = 1; step(); step(); clr();
        chk("to_change", 8'(nchg), 8'd2);
        // reset during refund holding 4
        do_reset();
        {twoin, fivein} = 2'b11; step(); clr();
        disp_ready = 1; step(); clr();
        disp_done = 1; step(); clr();
        step();
        chk("rst_pre_credit", 8'(credit), 8'd4);
        do_reset();
        hop_ready = 1; step(); step(); clr();
        chk("rst_change", 8'(nchg), 8'd0);
        chk("rst_credit", 8'(credit), 8'd0);
        // random traffic
        for (int i = 0; i < 3000; i++) begin
            onein = $urandom_range(7) == 0;
            twoin = $urandom_range(7) == 0;
            fivein = $urandom_range(11) == 0;
            cancel = $urandom_range(15) == 0;
            disp_ready = $urandom_range(1) == 0;
            disp_done = $urandom_range(3) == 0;
            hop_ready = $urandom_range(3) != 0;
            if ($urandom_range(199) == 0) do_reset();
            step();
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/vend_sequencer.md
VEND_SEQUENCER -- requirements
Module: vend_sequencer

Interface
REQ-001 Parameter: PRICE, default 3, vend price in coin units (1..7).
REQ-002 Parameter: TIMEOUT, default 16, idle cycles in COLLECT before auto-refund (2..255).
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-004 Port: clk  in  1  rising-edge clock.
REQ-005 Port: reset  in  1  asynchronous, active-high reset.
REQ-006 Port: onein  in  1  one-cycle pulse, 1-unit coin.
REQ-007 Port: twoin  in  1  one-cycle pulse, 2-unit coin.
REQ-008 Port: fivein  in  1  one-cycle pulse, 5-unit coin.
REQ-009 Port: cancel  in  1  user refund request, level-sampled.
REQ-010 Port: disp_ready  in  1  dispenser can accept a vend command.
REQ-011 Port: disp_done  in  1  one-cycle pulse, dispense finished.
REQ-012 Port: hop_ready  in  1  change hopper accepts one unit this cycle.
REQ-013 Port: water  out  1  registered one-cycle vend command.
REQ-014 Port: change  out  1  registered one-cycle pulse, one unit returned.
REQ-015 Port: coin_rej  out  1  registered one-cycle pulse, coin(s) refused.
REQ-016 Port: credit  out  4  current credit, registered.
REQ-017 Port: busy  out  1  high in VEND, WAIT_DONE, REFUND (decoded from state).

Function
REQ-018 States: IDLE, COLLECT, VEND, WAIT_DONE, REFUND; credit never exceeds 4 bits (max PRICE-1+8 = 14).
REQ-019 Coin sum per cycle = 1*onein + 2*twoin + 5*fivein; simultaneous coins all accepted (all three -> +8).
REQ-020 IDLE: credit = 0; nonzero sum -> credit = sum, next = VEND if sum >= PRICE else COLLECT.
REQ-021 COLLECT: sum added to credit each cycle; next = VEND if new credit >= PRICE.
REQ-022 COLLECT: cancel=1 -> REFUND; coin in same cycle added first, cancel takes precedence over VEND.
REQ-023 COLLECT: timeout counter clears on entry and on any accepted coin; after TIMEOUT consecutive coin-free cycles -> REFUND.
REQ-024 VEND: wait while disp_ready=0; on disp_ready=1, water=1 next cycle for exactly one cycle, credit -= PRICE, next = WAIT_DONE.
REQ-025 WAIT_DONE: wait for disp_done; then REFUND if credit > 0, else IDLE.
REQ-026 REFUND: each cycle with hop_ready=1 and credit > 0, change=1 next cycle, credit -= 1; when credit becomes 0 -> IDLE.
REQ-027 REFUND: hop_ready=0 stalls, credit and state unchanged, no change pulse.
REQ-028 Coins in VEND, WAIT_DONE or REFUND SHALL NOT alter credit; coin_rej=1 the following cycle.
REQ-029 cancel ignored outside COLLECT; disp_done ignored outside WAIT_DONE.
REQ-030 water and change SHALL never be high in the same cycle.

Reset
REQ-031 reset=1 asynchronously forces IDLE, credit=0, timeout counter=0, water=change=coin_rej=0, busy=0.
REQ-032 Reset mid-VEND, WAIT_DONE or REFUND discards credit; no pending pulse emitted after release.
REQ-033 First state update occurs on the first clk edge after reset deasserts.

Verification
REQ-034 Exact pay: twoin, then onein next cycle, disp_ready=1 -> water pulse once, credit 0, disp_done -> IDLE, no change pulses.
REQ-035 Overpay: fivein in IDLE, disp_ready=1, disp_done, hop_ready=1 -> water once, credit 2 -> 1 -> 0, exactly two change pulses, IDLE.
REQ-036 Simultaneous coins: onein+twoin+fivein same cycle -> credit 8, vend, then five change pulses; a coin during REFUND -> coin_rej pulse, credit unaffected.
REQ-037 Cancel: onein, then cancel -> REFUND, one change pulse with hop_ready=1, no water; hop_ready=0 for 3 cycles stalls with credit held at 1.
REQ-038 Timeout: onein then 16 coin-free cycles -> REFUND entered, one change pulse; a coin at cycle 15 restarts the count.
REQ-039 Reset during REFUND with credit 4 -> credit 0, IDLE, no change pulse after release.
